// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button step pulser.
package btn_pkg;

  localparam int unsigned DEF_DEB_CYCLES = 500000;
  localparam int unsigned DEF_REP_DELAY  = 50000000;
  localparam int unsigned DEF_REP_PERIOD = 10000000;
  localparam int unsigned DEF_CNT_W      = 26;

  // ST_HELD is the single-pulse build's only post-press state.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT,
    ST_LOCK,
    ST_HELD
  } btn_state_t;

endpackage

// File: rtl/btn_step_pulser_if.sv
// Button inputs, edit-mode enable and step-pulse outputs of the pulser.
interface btn_step_pulser_if;

  logic EN;
  logic BTN_UP;
  logic BTN_DOWN;
  logic UP;
  logic DOWN;

  modport master (output EN, BTN_UP, BTN_DOWN, input UP, DOWN);
  modport slave  (input EN, BTN_UP, BTN_DOWN, output UP, DOWN);

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, run-length debounce, rising-edge detect.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          stable;
  logic          stable_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync     <= '0;
      cnt      <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      sync     <= {sync[0], btn};
      stable_d <= stable;
      // Any agreeing cycle restarts the run of differing cycles.
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        cnt    <= '0;
        stable <= ~stable;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign level = stable;
  assign rise  = stable & ~stable_d;

endmodule

// File: rtl/btn_step_pulser.sv
// Turns raw UP/DOWN buttons into one-cycle step pulses for time-field editing.
// Define BTN_AUTOREPEAT_EN to build hold-to-repeat; otherwise one pulse per press.
module btn_step_pulser
  import btn_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned REP_DELAY  = DEF_REP_DELAY,
  parameter int unsigned REP_PERIOD = DEF_REP_PERIOD,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  btn_step_pulser_if.slave bus
);

  localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;

  if (REP_DELAY < 1 || REP_PERIOD < 1 || $clog2(REP_MAX) > CNT_W) begin : g_bad_cfg
    $error("btn_step_pulser: CNT_W cannot hold the repeat timing");
  end

  logic stb_up, stb_dn, rise_up, rise_dn;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .CLK   (CLK),
    .RST   (RST),
    .btn   (bus.BTN_UP),
    .level (stb_up),
    .rise  (rise_up)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .CLK   (CLK),
    .RST   (RST),
    .btn   (bus.BTN_DOWN),
    .level (stb_dn),
    .rise  (rise_dn)
  );

  btn_state_t st, st_nxt;
  logic       act_dn, act_dn_nxt;
  logic       up_q, dn_q, up_nxt, dn_nxt;
  logic       act_lvl, oth_lvl;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_TERM  = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_TERM = CNT_W'(REP_PERIOD - 1);
  localparam btn_state_t       ST_PRESSED  = ST_DELAY;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
`else
  localparam btn_state_t       ST_PRESSED  = ST_HELD;
`endif

  always_comb begin
    st_nxt     = st;
    act_dn_nxt = act_dn;
    up_nxt     = 1'b0;
    dn_nxt     = 1'b0;
    act_lvl    = act_dn ? stb_dn : stb_up;
    oth_lvl    = act_dn ? stb_up : stb_dn;
`ifdef BTN_AUTOREPEAT_EN
    cnt_inc    = (&cnt) ? cnt : cnt + CNT_W'(1);
    cnt_nxt    = '0;
`endif
    if (!bus.EN) begin
      st_nxt = ST_IDLE;
    end else begin
      case (st)
        ST_IDLE: begin
          // A rise implies its own level is high, so both levels high means a conflict.
          if ((rise_up || rise_dn) && stb_up && stb_dn) begin
            st_nxt = ST_LOCK;
          end else if (rise_up || rise_dn) begin
            act_dn_nxt = rise_dn;
            up_nxt     = rise_up;
            dn_nxt     = rise_dn;
            st_nxt     = ST_PRESSED;
          end
        end
`ifdef BTN_AUTOREPEAT_EN
        ST_DELAY, ST_REPEAT: begin
          cnt_nxt = cnt_inc;
          if (!act_lvl) begin
            st_nxt  = ST_IDLE;
            cnt_nxt = '0;
          end else if (oth_lvl) begin
            st_nxt  = ST_LOCK;
            cnt_nxt = '0;
          end else if (cnt == ((st == ST_DELAY) ? DELAY_TERM : PERIOD_TERM)) begin
            up_nxt  = ~act_dn;
            dn_nxt  = act_dn;
            cnt_nxt = '0;
            st_nxt  = ST_REPEAT;
          end
        end
`else
        ST_HELD: begin
          if (!act_lvl) begin
            st_nxt = ST_IDLE;
          end else if (oth_lvl) begin
            st_nxt = ST_LOCK;
          end
        end
`endif
        ST_LOCK: begin
          if (!stb_up && !stb_dn) begin
            st_nxt = ST_IDLE;
          end
        end
        default: st_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st     <= ST_IDLE;
      act_dn <= 1'b0;
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      cnt    <= '0;
`endif
    end else begin
      st     <= st_nxt;
      act_dn <= act_dn_nxt;
      up_q   <= up_nxt;
      dn_q   <= dn_nxt;
`ifdef BTN_AUTOREPEAT_EN
      cnt    <= cnt_nxt;
`endif
    end
  end

  assign bus.UP   = up_q;
  assign bus.DOWN = dn_q;

endmodule
